// File: rtl/pc_gen_pkg.sv
// Shared fetch-address constants and PC generator state encoding.
// Region nibbles are also used by the IMEM/BIOS fetch-source decode.
package pc_gen_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h4000_0000;
    localparam logic [3:0]  REGION_IMEM      = 4'h1;
    localparam logic [3:0]  REGION_BIOS      = 4'h4;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PEND  = 2'd2,
        ST_FAULT = 2'd3
    } pc_state_e;

endpackage

// File: rtl/pc_legal_chk.sv
// Next-PC legality: word aligned and inside the IMEM or BIOS region.
module pc_legal_chk
    import pc_gen_pkg::*;
(
    input  logic [31:0] addr,
    output logic        legal
);

    assign legal = (addr[1:0] == 2'b00) &&
                   ((addr[31:28] == REGION_IMEM) || (addr[31:28] == REGION_BIOS));

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: sequential/redirect next-PC selection with stall-deferred
// redirects and a sticky fault on any illegal next-PC.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_valid,
    output logic        fault,
    output logic [31:0] fault_addr
);

    pc_state_e   state_q, state_n;
    logic [31:0] pc_q, pc_n;
    logic [31:0] pend_q, pend_n;
    logic [31:0] faddr_q, faddr_n;
    logic        fv_q, fault_q;
    logic [31:0] cand;
    logic        apply;
    logic        cand_legal;

    pc_legal_chk u_legal (
        .addr  (cand),
        .legal (cand_legal)
    );

    always_comb begin
        state_n = state_q;
        pc_n    = pc_q;
        pend_n  = pend_q;
        faddr_n = faddr_q;
        cand    = pc_plus4;
        apply   = 1'b0;
        case (state_q)
            ST_BOOT: state_n = ST_RUN;
            ST_RUN: begin
                if (!stall) begin
                    apply = 1'b1;
                    cand  = redirect_valid ? redirect_target : pc_plus4;
                end else if (redirect_valid) begin
                    pend_n  = redirect_target;
                    state_n = ST_PEND;
                end
            end
            ST_PEND: begin
                if (stall) begin
                    if (redirect_valid) pend_n = redirect_target;
                end else begin
                    apply   = 1'b1;
                    cand    = redirect_valid ? redirect_target : pend_q;
                    state_n = ST_RUN;
                end
            end
            default: ; // FAULT absorbs everything until reset
        endcase
        // An illegal candidate leaves pc where it is and records the culprit
        if (apply) begin
            if (cand_legal) begin
                pc_n = cand;
            end else begin
                faddr_n = cand;
                state_n = ST_FAULT;
            end
        end
    end

    // Status outputs are registered from the next state so outputs stay logic-free
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            pend_q  <= 32'h0;
            faddr_q <= 32'h0;
            fv_q    <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_n;
            pc_q    <= pc_n;
            pend_q  <= pend_n;
            faddr_q <= faddr_n;
            fv_q    <= (state_n == ST_RUN);
            fault_q <= (state_n == ST_FAULT);
        end
    end

    assign pc          = pc_q;
    assign pc_plus4    = pc_q + 32'd4;
    assign fetch_valid = fv_q;
    assign fault       = fault_q;
    assign fault_addr  = faddr_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: boot sequence, redirects, stall-deferred redirects,
// fault cases and asynchronous reset from PEND and FAULT.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] pc, pc_plus4, fault_addr;
    logic        fetch_valid, fault;

    int checks   = 0;
    int failures = 0;

    pc_gen #(.RESET_PC(32'h4000_0000)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .pc              (pc),
        .pc_plus4        (pc_plus4),
        .fetch_valid     (fetch_valid),
        .fault           (fault),
        .fault_addr      (fault_addr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic [31:0] epc, input logic efv,
                             input logic eflt, input logic [31:0] efa);
        chk({tag, ".pc"},    pc,          epc);
        chk({tag, ".pc4"},   pc_plus4,    epc + 32'd4);
        chk({tag, ".fv"},    {31'b0, fetch_valid}, {31'b0, efv});
        chk({tag, ".fault"}, {31'b0, fault},       {31'b0, eflt});
        chk({tag, ".faddr"}, fault_addr,  efa);
    endtask

    task automatic drive(input logic s, input logic rv, input logic [31:0] tgt);
        stall           = s;
        redirect_valid  = rv;
        redirect_target = tgt;
    endtask

    task automatic reset_release();
        @(negedge clk);
        reset_n = 1'b1;
        #1;
    endtask

    initial begin
        reset_n = 1'b1;
        drive(1'b0, 1'b0, 32'h0);
        #2 reset_n = 1'b0;
        #1 chk_state("reset", 32'h4000_0000, 1'b0, 1'b0, 32'h0);
        tick();
        tick();
        chk_state("reset_held", 32'h4000_0000, 1'b0, 1'b0, 32'h0);

        // Boot sequence
        reset_release();
        chk_state("boot", 32'h4000_0000, 1'b0, 1'b0, 32'h0);
        tick(); chk_state("run0", 32'h4000_0000, 1'b1, 1'b0, 32'h0);
        tick(); chk_state("run1", 32'h4000_0004, 1'b1, 1'b0, 32'h0);
        tick(); chk_state("run2", 32'h4000_0008, 1'b1, 1'b0, 32'h0);
        tick(); chk_state("run3", 32'h4000_000C, 1'b1, 1'b0, 32'h0);
        tick(); chk_state("run4", 32'h4000_0010, 1'b1, 1'b0, 32'h0);

        // Redirect beats sequential increment
        drive(1'b0, 1'b1, 32'h1000_0020);
        tick(); chk_state("redir", 32'h1000_0020, 1'b1, 1'b0, 32'h0);

        // Plain stall holds pc
        drive(1'b1, 1'b0, 32'h0);
        tick(); chk_state("stall_hold", 32'h1000_0020, 1'b1, 1'b0, 32'h0);

        // Stalled redirects: newest pending target wins
        drive(1'b1, 1'b1, 32'h1000_0100);
        tick(); chk_state("pend0", 32'h1000_0020, 1'b0, 1'b0, 32'h0);
        drive(1'b1, 1'b1, 32'h1000_0200);
        tick(); chk_state("pend1", 32'h1000_0020, 1'b0, 1'b0, 32'h0);
        drive(1'b1, 1'b0, 32'h0);
        tick(); chk_state("pend2", 32'h1000_0020, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 32'h0);
        tick(); chk_state("pend_apply", 32'h1000_0200, 1'b1, 1'b0, 32'h0);
        tick(); chk_state("pend_seq", 32'h1000_0204, 1'b1, 1'b0, 32'h0);

        // Fresh redirect on PEND release overrides the pending target
        drive(1'b1, 1'b1, 32'h1000_0300);
        tick(); chk_state("pend3", 32'h1000_0204, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 1'b1, 32'h4000_0100);
        tick(); chk_state("pend_override", 32'h4000_0100, 1'b1, 1'b0, 32'h0);

        // Sequential crossing out of IMEM faults
        drive(1'b0, 1'b1, 32'h1FFF_FFF8);
        tick(); chk_state("edge0", 32'h1FFF_FFF8, 1'b1, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 32'h0);
        tick(); chk_state("edge1", 32'h1FFF_FFFC, 1'b1, 1'b0, 32'h0);
        tick(); chk_state("edge_fault", 32'h1FFF_FFFC, 1'b0, 1'b1, 32'h2000_0000);

        // Asynchronous reset out of FAULT
        #2 reset_n = 1'b0;
        #1 chk_state("rst_fault", 32'h4000_0000, 1'b0, 1'b0, 32'h0);
        reset_release();
        tick(); chk_state("rerun", 32'h4000_0000, 1'b1, 1'b0, 32'h0);

        // Misaligned redirect faults, then FAULT is absorbing under random inputs
        drive(1'b0, 1'b1, 32'h1000_0022);
        tick(); chk_state("misalign", 32'h4000_0000, 1'b0, 1'b1, 32'h1000_0022);
        for (int i = 0; i < 20; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 32'h1000_0000 | ($urandom & 32'h0FFF_FFFC));
            tick();
            chk_state("absorb", 32'h4000_0000, 1'b0, 1'b1, 32'h1000_0022);
        end

        // Illegal region via PEND release also faults
        #2 reset_n = 1'b0;
        #1 chk_state("rst2", 32'h4000_0000, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 32'h0);
        reset_release();
        tick();
        drive(1'b1, 1'b1, 32'h3000_0000);
        tick(); chk_state("pend_bad", 32'h4000_0000, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 32'h0);
        tick(); chk_state("pend_bad_fault", 32'h4000_0000, 1'b0, 1'b1, 32'h3000_0000);

        // Asynchronous reset out of PEND discards the pending target
        #2 reset_n = 1'b0;
        #1 drive(1'b0, 1'b0, 32'h0);
        reset_release();
        tick();
        drive(1'b1, 1'b1, 32'h1000_0300);
        tick(); chk_state("pend4", 32'h4000_0000, 1'b0, 1'b0, 32'h0);
        #2 reset_n = 1'b0;
        #1 chk_state("rst_pend", 32'h4000_0000, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 32'h0);
        reset_release();
        chk_state("boot2", 32'h4000_0000, 1'b0, 1'b0, 32'h0);
        tick(); chk_state("post_pend0", 32'h4000_0000, 1'b1, 1'b0, 32'h0);
        tick(); chk_state("post_pend1", 32'h4000_0004, 1'b1, 1'b0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
